// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared constants and channel state encoding for the
//               dual-channel encoder pulse counter.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int C_CNT_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_Z = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/enc_if.sv
`default_nettype none
// ============================================================================
// Module      : enc_if
// Description : Encoder pin / DAQ-side bundle; master drives the pins,
//               slave (enc_top) returns conditioned signals and counts.
// Revision    : 1.0 - initial release
// ============================================================================
interface enc_if
    import enc_pkg::*;
#(
    parameter int P_CNT_W = C_CNT_W
);
    logic               I_ARM;
    logic               I_SEL;
    logic               I_A0;
    logic               I_A1;
    logic               I_Z0;
    logic               I_Z1;
    logic               O_A0;
    logic               O_A1;
    logic               O_Z0;
    logic               O_Z1;
    logic               O_SEL;
    logic [P_CNT_W-1:0] O_CNT_A0;
    logic [P_CNT_W-1:0] O_CNT_A1;
    logic               O_OVERFLOW_0;
    logic               O_OVERFLOW_1;
    logic               O_READY_0;
    logic               O_READY_1;

    modport master (
        output I_ARM, I_SEL, I_A0, I_A1, I_Z0, I_Z1,
        input  O_A0, O_A1, O_Z0, O_Z1, O_SEL, O_CNT_A0, O_CNT_A1,
        input  O_OVERFLOW_0, O_OVERFLOW_1, O_READY_0, O_READY_1
    );

    modport slave (
        input  I_ARM, I_SEL, I_A0, I_A1, I_Z0, I_Z1,
        output O_A0, O_A1, O_Z0, O_Z1, O_SEL, O_CNT_A0, O_CNT_A1,
        output O_OVERFLOW_0, O_OVERFLOW_1, O_READY_0, O_READY_1
    );
endinterface
`default_nettype wire

// File: rtl/enc_cnt.sv
`default_nettype none
// ============================================================================
// Module      : enc_cnt
// Description : One encoder channel: input conditioning, edge detect,
//               arm/index FSM, wrapping counter with sticky overflow.
//               ENC_INPUT_SYNC_EN selects 2-flop synchronizers on A/Z.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_cnt
    import enc_pkg::*;
#(
    parameter int P_CNT_W = C_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_arm,
    input  logic               i_a,
    input  logic               i_z,
    output logic               o_a,
    output logic               o_z,
    output logic [P_CNT_W-1:0] o_cnt,
    output logic               o_overflow,
    output logic               o_ready
);
    logic               r_a_sync;
    logic               r_z_sync;
    logic               r_a_dly;
    logic               r_z_dly;
    logic               w_a_rise;
    logic               w_z_rise;
    logic               w_stm_active;
    logic [P_CNT_W-1:0] r_cnt;
    logic               r_overflow;
    state_t             r_state;
    state_t             w_state_nxt;

`ifdef ENC_INPUT_SYNC_EN
    logic r_a_meta;
    logic r_z_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_meta <= 1'b0;
            r_z_meta <= 1'b0;
            r_a_sync <= 1'b0;
            r_z_sync <= 1'b0;
        end else begin
            r_a_meta <= i_a;
            r_z_meta <= i_z;
            r_a_sync <= r_a_meta;
            r_z_sync <= r_z_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sync <= 1'b0;
            r_z_sync <= 1'b0;
        end else begin
            r_a_sync <= i_a;
            r_z_sync <= i_z;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_dly <= 1'b0;
            r_z_dly <= 1'b0;
        end else begin
            r_a_dly <= r_a_sync;
            r_z_dly <= r_z_sync;
        end
    end

    assign w_a_rise = r_a_sync & ~r_a_dly;
    assign w_z_rise = r_z_sync & ~r_z_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_stm_active = (r_state == ACTIVE);
        if (!i_arm) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = WAIT_Z;
                WAIT_Z:  if (w_z_rise) w_state_nxt = ACTIVE;
                ACTIVE:  w_state_nxt = ACTIVE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // The entering index zeroes the count, so an A edge on that cycle is lost.
    always_ff @(posedge clk) begin
        if (rst || !i_arm) begin
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else if ((r_state == WAIT_Z) && w_z_rise) begin
            r_cnt <= '0;
        end else if (w_stm_active && w_a_rise) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_a        = r_a_dly;
    assign o_z        = r_z_dly;
    assign o_cnt      = r_cnt;
    assign o_overflow = r_overflow;
    assign o_ready    = w_stm_active;

endmodule
`default_nettype wire

// File: rtl/enc_top.sv
`default_nettype none
// ============================================================================
// Module      : enc_top
// Description : Dual-channel incremental-encoder pulse counter; registers
//               ARM/SEL and runs two independent enc_cnt channels.
//               Input synchronizer depth set by ENC_INPUT_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_top
    import enc_pkg::*;
#(
    parameter int P_CNT_W = C_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    enc_if.slave bus
);
    logic r_arm;
    logic r_sel;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_arm <= 1'b0;
            r_sel <= 1'b0;
        end else begin
            r_arm <= bus.I_ARM;
            r_sel <= bus.I_SEL;
        end
    end

    assign bus.O_SEL = r_sel;

    enc_cnt #(
        .P_CNT_W (P_CNT_W)
    ) ENC_CNT0 (
        .clk        (CLK),
        .rst        (RST),
        .i_arm      (r_arm),
        .i_a        (bus.I_A0),
        .i_z        (bus.I_Z0),
        .o_a        (bus.O_A0),
        .o_z        (bus.O_Z0),
        .o_cnt      (bus.O_CNT_A0),
        .o_overflow (bus.O_OVERFLOW_0),
        .o_ready    (bus.O_READY_0)
    );

    enc_cnt #(
        .P_CNT_W (P_CNT_W)
    ) ENC_CNT1 (
        .clk        (CLK),
        .rst        (RST),
        .i_arm      (r_arm),
        .i_a        (bus.I_A1),
        .i_z        (bus.I_Z1),
        .o_a        (bus.O_A1),
        .o_z        (bus.O_Z1),
        .o_cnt      (bus.O_CNT_A1),
        .o_overflow (bus.O_OVERFLOW_1),
        .o_ready    (bus.O_READY_1)
    );

endmodule
`default_nettype wire

// File: tb/tb_enc_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_enc_top
// Description : Directed self-checking bench for enc_top (both settings of
//               ENC_INPUT_SYNC_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_top;

`ifdef ENC_INPUT_SYNC_EN
    localparam int C_LAT = 3;
`else
    localparam int C_LAT = 2;
`endif

    logic CLK = 1'b0;
    logic RST;
    int   n_total = 0;
    int   n_bad   = 0;

    enc_if #(.P_CNT_W(64)) bus ();

    enc_top #(.P_CNT_W(64)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #4 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_a0();
        bus.I_A0 = 1'b1; wait_n(2);
        bus.I_A0 = 1'b0; wait_n(2);
    endtask

    task automatic pulse_z(input logic z0, input logic z1);
        bus.I_Z0 = z0; bus.I_Z1 = z1; wait_n(2);
        bus.I_Z0 = 1'b0; bus.I_Z1 = 1'b0; wait_n(2);
    endtask

    task automatic rearm();
        bus.I_ARM = 1'b0; wait_n(3);
        bus.I_ARM = 1'b1; wait_n(4);
    endtask

    initial begin
        int lat;
        RST = 1'b1;
        bus.I_ARM = 1'b0; bus.I_SEL = 1'b0;
        bus.I_A0 = 1'b0; bus.I_A1 = 1'b0; bus.I_Z0 = 1'b0; bus.I_Z1 = 1'b0;

        // Reset state
        wait_n(2);
        check("rst_cnt0", bus.O_CNT_A0, 64'd0);
        check("rst_cnt1", bus.O_CNT_A1, 64'd0);
        check("rst_rdy0", {63'd0, bus.O_READY_0}, 64'd0);
        check("rst_rdy1", {63'd0, bus.O_READY_1}, 64'd0);
        check("rst_ovf", {62'd0, bus.O_OVERFLOW_1, bus.O_OVERFLOW_0}, 64'd0);
        check("rst_misc", {59'd0, bus.O_A0, bus.O_A1, bus.O_Z0, bus.O_Z1, bus.O_SEL}, 64'd0);
        RST = 1'b0;
        wait_n(1);

        // Disarmed: pulses on every input are ignored
        for (int i = 0; i < 500; i++) begin
            bus.I_A0 = 1'b1; bus.I_A1 = 1'b1; bus.I_Z0 = (i % 3 == 0); bus.I_Z1 = (i % 3 == 0);
            wait_n(1);
            bus.I_A0 = 1'b0; bus.I_A1 = 1'b0; bus.I_Z0 = 1'b0; bus.I_Z1 = 1'b0;
            wait_n(1);
        end
        wait_n(4);
        check("disarm_cnt0", bus.O_CNT_A0, 64'd0);
        check("disarm_cnt1", bus.O_CNT_A1, 64'd0);
        check("disarm_rdy0", {63'd0, bus.O_READY_0}, 64'd0);

        // Armed, A before index ignored
        bus.I_ARM = 1'b1; wait_n(4);
        check("waitz_rdy0", {63'd0, bus.O_READY_0}, 64'd0);
        repeat (3) pulse_a0();
        check("pre_z_cnt0", bus.O_CNT_A0, 64'd0);
        check("pre_z_rdy0", {63'd0, bus.O_READY_0}, 64'd0);
        pulse_z(1'b1, 1'b0);
        check("idx_rdy0", {63'd0, bus.O_READY_0}, 64'd1);
        check("idx_cnt0", bus.O_CNT_A0, 64'd0);

        // Counting with index pulses after every third A
        for (int i = 1; i <= 500; i++) begin
            pulse_a0();
            check("step_cnt0", bus.O_CNT_A0, 64'(i));
            if (i % 3 == 0) pulse_z(1'b1, 1'b0);
        end
        check("ch1_noidx_cnt", bus.O_CNT_A1, 64'd0);
        check("ch1_noidx_rdy", {63'd0, bus.O_READY_1}, 64'd0);

        // Disarm clears, then both channels at different rates
        bus.I_ARM = 1'b0; wait_n(3);
        check("disarm2_cnt0", bus.O_CNT_A0, 64'd0);
        check("disarm2_rdy0", {63'd0, bus.O_READY_0}, 64'd0);
        bus.I_ARM = 1'b1; wait_n(4);
        pulse_z(1'b1, 1'b1);
        check("both_rdy", {62'd0, bus.O_READY_1, bus.O_READY_0}, 64'd3);
        for (int k = 0; k < 120; k++) begin
            bus.I_A0 = (k % 2 == 1);
            bus.I_A1 = (k % 6 >= 3);
            if (k == 40) begin
                bus.I_SEL = 1'b1;
                #1 check("sel_hold", {63'd0, bus.O_SEL}, 64'd0);
            end
            if (k == 41) check("sel_rise", {63'd0, bus.O_SEL}, 64'd1);
            if (k == 60) bus.I_SEL = 1'b0;
            if (k == 61) check("sel_fall", {63'd0, bus.O_SEL}, 64'd0);
            wait_n(1);
        end
        bus.I_A0 = 1'b0; bus.I_A1 = 1'b0; wait_n(5);
        check("rate_cnt0", bus.O_CNT_A0, 64'd60);
        check("rate_cnt1", bus.O_CNT_A1, 64'd20);

        // Overflow wrap and sticky flag
        force dut.ENC_CNT0.r_cnt = {64{1'b1}};
        wait_n(1);
        release dut.ENC_CNT0.r_cnt;
        wait_n(1);
        pulse_a0();
        check("wrap_cnt0", bus.O_CNT_A0, 64'd0);
        check("wrap_ovf0", {63'd0, bus.O_OVERFLOW_0}, 64'd1);
        check("wrap_ovf1", {63'd0, bus.O_OVERFLOW_1}, 64'd0);
        check("wrap_cnt1", bus.O_CNT_A1, 64'd20);
        pulse_a0();
        check("sticky_cnt0", bus.O_CNT_A0, 64'd1);
        check("sticky_ovf0", {63'd0, bus.O_OVERFLOW_0}, 64'd1);
        bus.I_ARM = 1'b0; wait_n(3);
        check("ovf_clr", {63'd0, bus.O_OVERFLOW_0}, 64'd0);
        check("ovf_clr_cnt0", bus.O_CNT_A0, 64'd0);
        check("ovf_clr_cnt1", bus.O_CNT_A1, 64'd0);

        // Re-arm five times, measure A-to-count latency
        for (int r = 0; r < 5; r++) begin
            rearm();
            pulse_a0();
            check("rearm_pre_cnt", bus.O_CNT_A0, 64'd0);
            pulse_z(1'b1, 1'b0);
            check("rearm_rdy", {63'd0, bus.O_READY_0}, 64'd1);
            bus.I_A0 = 1'b1;
            lat = 9;
            for (int n = 1; n <= 8; n++) begin
                @(posedge CLK); #1;
                if (bus.O_A0) begin
                    lat = n;
                    break;
                end
                check("lat_cnt_before", bus.O_CNT_A0, 64'd0);
            end
            check("lat_edges", 64'(lat), 64'(C_LAT));
            check("lat_cnt", bus.O_CNT_A0, 64'd1);
            @(negedge CLK);
            bus.I_A0 = 1'b0; wait_n(3);
        end

        // A rise in the same cycle as the entering index is not counted
        rearm();
        bus.I_A0 = 1'b1; bus.I_Z0 = 1'b1; wait_n(2);
        bus.I_A0 = 1'b0; bus.I_Z0 = 1'b0; wait_n(2);
        check("az_rdy", {63'd0, bus.O_READY_0}, 64'd1);
        check("az_cnt", bus.O_CNT_A0, 64'd0);
        pulse_a0();
        check("az_next_cnt", bus.O_CNT_A0, 64'd1);

        // Reset mid-operation with ARM still high
        bus.I_SEL = 1'b1; wait_n(2);
        check("pre_rst_sel", {63'd0, bus.O_SEL}, 64'd1);
        RST = 1'b1; wait_n(1);
        check("mid_rst_cnt0", bus.O_CNT_A0, 64'd0);
        check("mid_rst_rdy0", {63'd0, bus.O_READY_0}, 64'd0);
        check("mid_rst_sel", {63'd0, bus.O_SEL}, 64'd0);
        RST = 1'b0; wait_n(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
